// File: rtl/icache_line_filler_pkg.sv
// Shared geometry, FSM state encoding and line-address type for the I-cache fill path.
package icache_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int WORDS_PER_LINE   = 4;
  localparam int WORD_OFFSET_SIZE = 2;
  localparam int BYTE_OFFSET_SIZE = 2;
  localparam int LINE_OFFSET_SIZE = WORD_OFFSET_SIZE + BYTE_OFFSET_SIZE;
  localparam int INDEX_SIZE       = 6;
  localparam int TAG_SIZE         = ADDR_WIDTH - INDEX_SIZE - LINE_OFFSET_SIZE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WRITE  = 2'd2,
    SETTLE = 2'd3
  } fill_state_t;

  typedef logic [ADDR_WIDTH-LINE_OFFSET_SIZE-1:0] line_base_t;

endpackage

// File: rtl/icache_line_filler_if.sv
// Instruction-memory read port: one outstanding word request, completed by mem_valid.
interface icache_line_filler_if;
  logic [31:0] mem_addr;
  logic        mem_rden;
  logic        mem_valid;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_rden, input mem_valid, input mem_rdata);
  modport slave  (input mem_addr, input mem_rden, output mem_valid, output mem_rdata);
endinterface

// File: rtl/icache_line_filler.sv
// Line fill engine: fetches a 4-word line on miss and strobes it into the I-cache.
// Optional macro ICACHE_CRITICAL_WORD_FIRST_EN starts the fetch at the missing word.
module icache_line_filler
  import icache_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [ADDR_WIDTH-1:0]  Address,
  input  logic                   miss,
  input  logic                   hit,
  icache_line_filler_if.master   mem,
  output logic [31:0]            w0,
  output logic [31:0]            w1,
  output logic [31:0]            w2,
  output logic [31:0]            w3,
  output logic                   update,
  output logic                   cacheStall
);

  fill_state_t                 state;
  line_base_t                  line_base;
  logic [WORD_OFFSET_SIZE-1:0] cnt;
  logic [WORD_OFFSET_SIZE-1:0] cnt_inc;
  logic [WORD_OFFSET_SIZE-1:0] first_off;
  logic [WORD_OFFSET_SIZE-1:0] start_off;
  logic [31:0]                 line_buf [WORDS_PER_LINE];
  logic                        unused_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign first_off = Address[LINE_OFFSET_SIZE-1:BYTE_OFFSET_SIZE];
`else
  assign first_off = '0;
  assign start_off = '0;
`endif

  assign unused_addr = ^Address[LINE_OFFSET_SIZE-1:0];
  assign cnt_inc     = cnt + 1'b1;

  // The last word is the one whose successor (mod 4) is the first word requested.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      cnt          <= '0;
      line_base    <= '0;
      mem.mem_rden <= 1'b0;
      mem.mem_addr <= '0;
      update       <= 1'b0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start_off    <= '0;
`endif
      for (int unsigned i = 0; i < WORDS_PER_LINE; i++) begin
        line_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (miss && !hit) begin
            line_base    <= Address[ADDR_WIDTH-1:LINE_OFFSET_SIZE];
            cnt          <= first_off;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
            start_off    <= first_off;
`endif
            mem.mem_rden <= 1'b1;
            mem.mem_addr <= {Address[ADDR_WIDTH-1:LINE_OFFSET_SIZE], first_off,
                             {BYTE_OFFSET_SIZE{1'b0}}};
            state        <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_valid) begin
            line_buf[cnt] <= mem.mem_rdata;
            cnt           <= cnt_inc;
            if (cnt_inc == start_off) begin
              mem.mem_rden <= 1'b0;
              update       <= 1'b1;
              state        <= WRITE;
            end else begin
              mem.mem_addr <= {line_base, cnt_inc, {BYTE_OFFSET_SIZE{1'b0}}};
            end
          end
        end
        WRITE: begin
          update <= 1'b0;
          state  <= SETTLE;
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cacheStall = (state != IDLE) | miss;
  end

  assign w0 = line_buf[0];
  assign w1 = line_buf[1];
  assign w2 = line_buf[2];
  assign w3 = line_buf[3];

endmodule

// File: tb/tb_icache_line_filler.sv
// Directed self-checking bench for icache_line_filler with a latency-programmable memory.
module tb_icache_line_filler;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        miss;
  logic        hit;
  logic [31:0] w0, w1, w2, w3;
  logic        update;
  logic        cache_stall;

  int tests;
  int fails;

  int          lat;
  int          waitc;
  logic        model_valid;
  logic        spur;
  logic [31:0] model_rdata;

  icache_line_filler_if bus ();

  icache_line_filler dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .Address    (address),
    .miss       (miss),
    .hit        (hit),
    .mem        (bus),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .update     (update),
    .cacheStall (cache_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory answers each request after lat idle cycles with addr ^ 0xA5A5_0000.
  always @(negedge clk) begin
    if (!rst_n || !bus.mem_rden) begin
      model_valid = 1'b0;
      waitc       = 0;
    end else if (waitc >= lat) begin
      model_valid = 1'b1;
      model_rdata = bus.mem_addr ^ 32'hA5A5_0000;
      waitc       = 0;
    end else begin
      model_valid = 1'b0;
      waitc       = waitc + 1;
    end
  end

  assign bus.mem_valid = model_valid | spur;
  assign bus.mem_rdata = spur ? 32'hDEAD_BEEF : model_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int guard;
    int ups;
    rst_n = 1'b0; miss = 1'b0; hit = 1'b0; address = '0; lat = 0; spur = 1'b0;
    step(); step();
    tests++; if (bus.mem_rden !== 1'b0) begin fails++; $display("FAIL reset_rden got=%b exp=0", bus.mem_rden); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL reset_update got=%b exp=0", update); end
    tests++; if ({w0, w1, w2, w3} !== 128'h0) begin fails++; $display("FAIL reset_words got=%h %h %h %h exp=0", w0, w1, w2, w3); end
    tests++; if (cache_stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", cache_stall); end
    rst_n = 1'b1;
    step();
    lat = 3; address = 32'h0000_1234; miss = 1'b1;
    step();
    miss = 1'b0;
    guard = 0;
    while (!(bus.mem_rden === 1'b1 && bus.mem_addr[3:2] === 2'd2) && guard < 40) begin
      step();
      guard++;
    end
    tests++; if (guard >= 40) begin fails++; $display("FAIL reset_reach_cnt2 got=timeout exp=addr_0x1238"); end
    rst_n = 1'b0;
    #1;
    tests++; if (bus.mem_rden !== 1'b0) begin fails++; $display("FAIL async_reset_rden got=%b exp=0", bus.mem_rden); end
    tests++; if (update !== 1'b0) begin fails++; $display("FAIL async_reset_update got=%b exp=0", update); end
    tests++; if (cache_stall !== 1'b0) begin fails++; $display("FAIL async_reset_idle got=%b exp=0", cache_stall); end
    tests++; if (w0 !== 32'h0) begin fails++; $display("FAIL async_reset_w0 got=%h exp=0", w0); end
    step(); step();
    rst_n = 1'b1;
    ups = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (update === 1'b1) ups++;
    end
    tests++; if (ups !== 0) begin fails++; $display("FAIL reset_no_update got=%0d exp=0", ups); end
  endtask

  task automatic test_fill_l0();
    int stalls;
    int ups;
    int up_idx;
    logic [31:0] exp_a;
    logic [31:0] cw [4];
    lat = 0; address = 32'h0000_1234; miss = 1'b1; hit = 1'b0;
    step();
    miss = 1'b0;
    stalls = 0; ups = 0; up_idx = -1;
    for (int i = 0; i < 10; i++) begin
      if (i < 4) begin
        exp_a = 32'h0000_1230 + 32'(4 * i);
        tests++;
        if (bus.mem_rden !== 1'b1 || bus.mem_addr !== exp_a) begin
          fails++; $display("FAIL l0_req%0d got=rden%b/%h exp=rden1/%h", i, bus.mem_rden, bus.mem_addr, exp_a);
        end
      end
      if (cache_stall === 1'b1) stalls++;
      if (update === 1'b1) begin
        ups++; up_idx = i;
        cw[0] = w0; cw[1] = w1; cw[2] = w2; cw[3] = w3;
      end
      step();
    end
    tests++; if (ups !== 1) begin fails++; $display("FAIL l0_update_count got=%0d exp=1", ups); end
    tests++; if (up_idx !== 4) begin fails++; $display("FAIL l0_update_cycle got=%0d exp=4", up_idx); end
    tests++; if (stalls !== 6) begin fails++; $display("FAIL l0_stall_cycles got=%0d exp=6", stalls); end
    for (int k = 0; k < 4; k++) begin
      exp_a = 32'hA5A5_1230 + 32'(4 * k);
      tests++;
      if (cw[k] !== exp_a) begin fails++; $display("FAIL l0_w%0d got=%h exp=%h", k, cw[k], exp_a); end
    end
  endtask

  task automatic test_latency3();
    int reqs;
    int bad;
    int up_idx;
    lat = 3; address = 32'h0000_1234; miss = 1'b1;
    step();
    miss = 1'b0;
    reqs = 0; bad = 0; up_idx = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) address = 32'h0000_8000;
      if (bus.mem_rden === 1'b1) begin
        reqs++;
        if (bus.mem_addr[31:4] !== 28'h000_0123) bad++;
      end
      if (update === 1'b1 && up_idx < 0) up_idx = i;
      step();
    end
    address = 32'h0000_1234;
    tests++; if (reqs !== 16) begin fails++; $display("FAIL l3_req_cycles got=%0d exp=16", reqs); end
    tests++; if (bad !== 0) begin fails++; $display("FAIL l3_line_base_held got=%0d_bad exp=0", bad); end
    tests++; if (up_idx !== 16) begin fails++; $display("FAIL l3_update_cycle got=%0d exp=16", up_idx); end
    tests++; if (w3 !== 32'hA5A5_123C) begin fails++; $display("FAIL l3_w3 got=%h exp=a5a5123c", w3); end
  endtask

  task automatic test_spurious();
    int guard;
    spur = 1'b1;
    step();
    spur = 1'b0;
    tests++; if ({w0, w1, w2, w3} !== {32'hA5A5_1230, 32'hA5A5_1234, 32'hA5A5_1238, 32'hA5A5_123C}) begin
      fails++; $display("FAIL spur_idle_words got=%h %h %h %h exp=a5a51230..a5a5123c", w0, w1, w2, w3);
    end
    tests++; if (cache_stall !== 1'b0 || bus.mem_rden !== 1'b0) begin
      fails++; $display("FAIL spur_idle_state got=stall%b/rden%b exp=0/0", cache_stall, bus.mem_rden);
    end
    lat = 0; miss = 1'b1;
    step();
    miss = 1'b0;
    guard = 0;
    while (update !== 1'b1 && guard < 20) begin step(); guard++; end
    tests++; if (guard >= 20) begin fails++; $display("FAIL spur_fill_update got=timeout exp=pulse"); end
    step();
    spur = 1'b1;
    step();
    spur = 1'b0;
    tests++; if (w1 !== 32'hA5A5_1234) begin fails++; $display("FAIL spur_settle_w1 got=%h exp=a5a51234", w1); end
    tests++; if (cache_stall !== 1'b0 || bus.mem_rden !== 1'b0) begin
      fails++; $display("FAIL spur_settle_state got=stall%b/rden%b exp=0/0", cache_stall, bus.mem_rden);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    int low;
    lat = 0; address = 32'h0000_2000; miss = 1'b1;
    step();
    guard = 0;
    while (update !== 1'b1 && guard < 20) begin step(); guard++; end
    tests++; if (guard >= 20) begin fails++; $display("FAIL b2b_first_update got=timeout exp=pulse"); end
    low = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (cache_stall !== 1'b1) low++;
    end
    tests++; if (low !== 0) begin fails++; $display("FAIL b2b_stall_held got=%0d_low exp=0", low); end
    tests++; if (bus.mem_rden !== 1'b1 || bus.mem_addr !== 32'h0000_2000) begin
      fails++; $display("FAIL b2b_refill_start got=rden%b/%h exp=rden1/00002000", bus.mem_rden, bus.mem_addr);
    end
    miss = 1'b0;
    guard = 0;
    while (update !== 1'b1 && guard < 20) begin step(); guard++; end
    tests++; if (guard >= 20) begin fails++; $display("FAIL b2b_second_update got=timeout exp=pulse"); end
    hit = 1'b1;
    step(); step();
    tests++; if (cache_stall !== 1'b0) begin fails++; $display("FAIL b2b_hit_idle_stall got=%b exp=0", cache_stall); end
    tests++; if (w0 !== 32'hA5A5_2000) begin fails++; $display("FAIL b2b_w0 got=%h exp=a5a52000", w0); end
    hit = 1'b0;
  endtask

  task automatic test_word_order();
    logic [31:0] exp_order [4];
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    exp_order[0] = 32'h0000_1238; exp_order[1] = 32'h0000_123C;
    exp_order[2] = 32'h0000_1230; exp_order[3] = 32'h0000_1234;
`else
    exp_order[0] = 32'h0000_1230; exp_order[1] = 32'h0000_1234;
    exp_order[2] = 32'h0000_1238; exp_order[3] = 32'h0000_123C;
`endif
    lat = 0; address = 32'h0000_1238; miss = 1'b1;
    step();
    miss = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (bus.mem_rden !== 1'b1 || bus.mem_addr !== exp_order[i]) begin
        fails++; $display("FAIL order_req%0d got=rden%b/%h exp=rden1/%h", i, bus.mem_rden, bus.mem_addr, exp_order[i]);
      end
      step();
    end
    tests++; if (update !== 1'b1) begin fails++; $display("FAIL order_update got=%b exp=1", update); end
    tests++; if (w2 !== 32'hA5A5_1238) begin fails++; $display("FAIL order_w2 got=%h exp=a5a51238", w2); end
    tests++; if (w0 !== 32'hA5A5_1230) begin fails++; $display("FAIL order_w0 got=%h exp=a5a51230", w0); end
    step(); step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fill_l0();
    test_latency3();
    test_spurious();
    test_back_to_back();
    test_word_order();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_line_filler.md
Name: icache_line_filler

Overview:
- Memory-side fill engine for the 4-way set-associative instruction cache.
- Watches the cache's `miss`/`Address`, fetches the 16-byte line from instruction memory one word per handshake, and presents it on `w0`..`w3` with a one-cycle `update` pulse.
- Drives `cacheStall` so the fetch stage holds until the refilled line hits.
- Sits between the cache and the instruction-memory read port.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- WORDS_PER_LINE, 4, words per cache line. Fixed to 4 because `w0`..`w3` are discrete ports.
- WORD_OFFSET_SIZE, 2, log2(WORDS_PER_LINE).
- BYTE_OFFSET_SIZE, 2, byte offset within a word.

Ports:
- CLK  input  1  system clock. Rising edge used; the cache writes on the falling edge.
- RST_N  input  1  asynchronous active-low reset.
- Address  input  32  fetch PC, same signal the cache sees.
- miss  input  1  cache miss indication (combinational from cache).
- hit  input  1  cache hit indication.
- mem_addr  output  32  word-aligned read address to instruction memory.
- mem_rden  output  1  read request, held until accepted.
- mem_valid  input  1  read data valid; completes the request.
- mem_rdata  input  32  read data.
- w0, w1, w2, w3  output  32 each  line words, offsets 0..3.
- update  output  1  one-cycle line-write strobe to the cache.
- cacheStall  output  1  stall to fetch stage and cache.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; word counter=0.
  - mem_rden=0, mem_addr=0, w0..w3=0, update=0, line base=0.
  - Reset mid-fill abandons the fill and never pulses `update`.
- FSM states: IDLE, REQ, WRITE, SETTLE.
- IDLE:
  - On `miss=1` at a rising edge: latch line_base=Address[31:4], set counter=0, go to REQ.
  - `hit=1` or `miss=0`: remain.
- REQ:
  - mem_rden=1; mem_addr={line_base, cnt, 2'b00}.
  - On a rising edge with mem_valid=1: store mem_rdata into word[cnt] and increment cnt.
  - If cnt was 3, go to WRITE with mem_rden=0 in the next cycle. Otherwise issue the next address in the next cycle.
  - Only one outstanding request; mem_valid in the same cycle as the first request assertion is legal.
- WRITE: update=1 for exactly one cycle; w0..w3 stable. The cache captures at that cycle's falling edge. Next state SETTLE.
- SETTLE: one cycle for the cache `hit` to reflect the new line, then IDLE.
- cacheStall = (state != IDLE) | miss. Combinational, no added latency.
- w0..w3 hold their last fill value until the next fill overwrites them.
- Latency: a fill with per-word memory latency L (cycles from request to valid, L≥0) takes 4·(L+1) cycles in REQ, plus 1 WRITE, plus 1 SETTLE.
- Boundary conditions:
  - `Address` changing during a fill is ignored; line_base is latched.
  - mem_valid while not in REQ is ignored.
  - `miss` asserted in WRITE or SETTLE is not acted on until IDLE.
  - If `miss` is still high on return to IDLE (the line was evicted by random replacement or the PC moved), a new fill starts.
  - Counter wraps 3→0 only on the transition out of REQ.
  - Simultaneous RST_N low and mem_valid: reset wins.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Latch start_off=Address[3:2] at miss.
  - Request order is start_off, start_off+1, … modulo 4 (wrap-around).
  - Each word is still stored to its true offset.
  - Total REQ cycle count is unchanged; `update` timing is unchanged.
- Undefined: request order is always 0,1,2,3.

Decomposition:
- Package `icache_pkg` holds:
  - WORDS_PER_LINE, WORD_OFFSET_SIZE, BYTE_OFFSET_SIZE, INDEX_SIZE, TAG_SIZE.
  - Enum `fill_state_t` {IDLE, REQ, WRITE, SETTLE}.
  - A line-base-address typedef.
- No sub-module: the FSM, counter and 4-word buffer are one module.

Test Plan:
1. Reset with RST_N=0 mid-REQ at cnt=2 → mem_rden=0 and update=0 immediately (async); state IDLE; no update pulse ever follows.
2. miss=1, Address=0x0000_1234, memory L=0 returning addr^0xA5A5_0000 → mem_addr sequence 0x1230, 0x1234, 0x1238, 0x123C on 4 consecutive cycles. Then:
   - update high for exactly 1 cycle with w0=0xA5A5_1230 … w3=0xA5A5_123C.
   - cacheStall high for 6 cycles total.
3. L=3 per word → 16 REQ cycles, then update. Changing Address to 0x0000_8000 mid-fill does not alter mem_addr[31:4]=0x0000_123.
4. Spurious mem_valid=1 in IDLE and in SETTLE → no change to w0..w3, no state change.
5. miss held high after SETTLE → a second fill starts with no idle gap. With miss=0 and hit=1 → cacheStall=0 in IDLE.
6. With ICACHE_CRITICAL_WORD_FIRST_EN and Address=0x0000_1238 → mem_addr order 0x1238, 0x123C, 0x1230, 0x1234; w2 holds data from 0x1238 and w0 holds data from 0x1230.
